// File: rtl/wb_initiator.sv
// wb_initiator: single-command bus master for the uart register bus.
// Takes one command on a valid/ready port, runs one stb/ack cycle and
// returns read data and status as a one-cycle response pulse.
// Optional feature: define WB_INIT_TIMEOUT_EN to abort strobes that are
// not acknowledged within TIMEOUT cycles (response flagged with rsp_err).
module wb_initiator #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data_out,
  input  logic [DATA_W-1:0] wb_data_in,
  output logic              wb_we,
  output logic              wb_stb,
  input  logic              wb_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                wb_we_q, wb_we_d;
  logic                wb_stb_q, wb_stb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                stale_q, stale_d;
  logic                ack_ok;
  logic                timeout_hit;

  // An ack still high at the end of the previous response belongs to the
  // old transfer, so it is ignored during the first strobe cycle.
  assign ack_ok = wb_ack & ~stale_q;

`ifdef WB_INIT_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));

  // Timeout counter: zero while idle, counts unacknowledged strobe cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == STROBE && !ack_ok) begin
      cnt_d = timeout_hit ? 16'd0 : cnt_q + 16'd1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  // Next-state and next-output logic for the IDLE -> STROBE -> RESP cycle.
  always_comb begin
    state_d     = state_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_we_d     = wb_we_q;
    wb_stb_d    = wb_stb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    stale_d     = stale_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          wb_addr_d = cmd_addr;
          wb_data_d = cmd_wdata;
          wb_we_d   = cmd_we;
          wb_stb_d  = 1'b1;
          state_d   = STROBE;
        end
      end
      STROBE: begin
        stale_d = 1'b0;
        if (ack_ok) begin
          wb_stb_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wb_we_q ? '0 : wb_data_in;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (timeout_hit) begin
          wb_stb_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        wb_stb_d = 1'b0;
        wb_we_d  = 1'b0;
        stale_d  = wb_ack;
        state_d  = IDLE;
      end
      default: begin
        wb_stb_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      wb_we_q     <= 1'b0;
      wb_stb_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wb_we_q     <= wb_we_d;
      wb_stb_q    <= wb_stb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      stale_q     <= stale_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign wb_addr     = wb_addr_q;
  assign wb_data_out = wb_data_q;
  assign wb_we       = wb_we_q;
  assign wb_stb      = wb_stb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Testbench for wb_initiator: table of single transactions plus hand-written
// sequences for stale ack, reset during strobe and (if enabled) timeout.
module tb_wb_initiator;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [1:0] wb_addr;
  logic [7:0] wb_data_out;
  logic [7:0] wb_data_in;
  logic       wb_we;
  logic       wb_stb;
  logic       wb_ack;

  int checkCount = 0;
  int passCount  = 0;
  int rspCount   = 0;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    int         ackAt;
    logic [7:0] rdin;
    logic [7:0] expRdata;
    int         expStb;
    logic       expErr;
  } vec_t;

  vec_t vecs[5];

  wb_initiator #(.ADDR_W(2), .DATA_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_addr(wb_addr), .wb_data_out(wb_data_out), .wb_data_in(wb_data_in),
    .wb_we(wb_we), .wb_stb(wb_stb), .wb_ack(wb_ack)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Count every response pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) rspCount++;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    else
      passCount++;
  endtask

  // Run one transaction; the responder acks on strobe cycle v.ackAt (0 = never).
  task automatic applyStimulus(input vec_t v);
    int stbCycles;
    bit stable;
    @(negedge clk);
    checkOutput("ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_we     = v.we;
    cmd_addr   = v.addr;
    cmd_wdata  = v.wdata;
    wb_ack     = 1'b0;
    wb_data_in = 8'hEE;
    @(negedge clk);
    cmd_we    = ~v.we;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    stbCycles = 0;
    stable    = 1'b1;
    while (wb_stb === 1'b1 && stbCycles < 40) begin
      stbCycles++;
      if (wb_addr !== v.addr || wb_data_out !== v.wdata || wb_we !== v.we || cmd_ready !== 1'b0 || rsp_valid !== 1'b0)
        stable = 1'b0;
      if (stbCycles == v.ackAt) begin
        wb_ack     = 1'b1;
        wb_data_in = v.rdin;
      end else begin
        wb_ack     = 1'b0;
        wb_data_in = 8'hEE;
      end
      @(negedge clk);
    end
    cmd_valid  = 1'b0;
    wb_ack     = 1'b0;
    wb_data_in = 8'hEE;
    checkOutput("bus_stable", 32'(stable), 32'd1);
    checkOutput("stb_cycles", 32'(stbCycles), 32'(v.expStb));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(v.expRdata));
    checkOutput("rsp_err", 32'(rsp_err), 32'(v.expErr));
    checkOutput("ready_in_resp", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    checkOutput("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    checkOutput("ready_back", 32'(cmd_ready), 32'd1);
    checkOutput("we_cleared", 32'(wb_we), 32'd0);
    checkOutput("rsp_hold", 32'(rsp_rdata), 32'(v.expRdata));
  endtask

  initial begin
    int rspBefore;
    // {we, addr, wdata, ackAt, rdin, expRdata, expStb, expErr}
    vecs[0] = '{1'b1, 2'd2, 8'hA5, 1, 8'hFF, 8'h00, 1, 1'b0};
    vecs[1] = '{1'b0, 2'd1, 8'h00, 4, 8'h3C, 8'h3C, 4, 1'b0};
    vecs[2] = '{1'b0, 2'd3, 8'h00, 1, 8'hC3, 8'hC3, 1, 1'b0};
    vecs[3] = '{1'b1, 2'd0, 8'h5A, 2, 8'h77, 8'h00, 2, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 8'h00, 3, 8'h81, 8'h81, 3, 1'b0};

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_addr   = 2'd0;
    cmd_wdata  = 8'h00;
    wb_data_in = 8'h00;
    wb_ack     = 1'b0;

    // Reset state after two reset cycles.
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_stb", 32'(wb_stb), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_bus", 32'({wb_addr, wb_data_out, wb_we}), 32'd0);
    checkOutput("rst_rsp", 32'({rsp_rdata, rsp_err}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);
    checkOutput("rsp_count_table", 32'(rspCount), 32'd5);

    // Stale ack: ack stays high from cmd1's strobe through cmd2's 2nd strobe cycle.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("st1_stb", 32'(wb_stb), 32'd1);
    wb_ack = 1'b1; wb_data_in = 8'h11;
    @(negedge clk);
    checkOutput("st1_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("st1_rdata", 32'(rsp_rdata), 32'h11);
    @(negedge clk);
    checkOutput("st_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_addr = 2'd3; wb_data_in = 8'h22;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("st2_stb_c1", 32'(wb_stb), 32'd1);
    checkOutput("st2_addr", 32'(wb_addr), 32'd3);
    @(negedge clk);
    checkOutput("st2_stb_c2", 32'(wb_stb), 32'd1);
    checkOutput("st2_no_early_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    wb_ack = 1'b0;
    checkOutput("st2_stb_low", 32'(wb_stb), 32'd0);
    checkOutput("st2_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("st2_rdata", 32'(rsp_rdata), 32'h22);
    @(negedge clk);
    checkOutput("st_rsp_count", 32'(rspCount), 32'd7);
    checkOutput("st_ready_back", 32'(cmd_ready), 32'd1);

    // Reset during the second strobe cycle of a read.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 2'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("mr_stb_c1", 32'(wb_stb), 32'd1);
    @(negedge clk);
    rspBefore = rspCount;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mr_stb", 32'(wb_stb), 32'd0);
    checkOutput("mr_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mr_bus", 32'({wb_addr, wb_we}), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mr_no_rsp", 32'(rspCount), 32'(rspBefore));
    checkOutput("mr_stb_idle", 32'(wb_stb), 32'd0);

`ifdef WB_INIT_TIMEOUT_EN
    // Timeout with TIMEOUT=4: no ack aborts after 4 strobe cycles; ack on the 4th wins.
    applyStimulus('{1'b0, 2'd2, 8'h00, 0, 8'h77, 8'h00, 4, 1'b1});
    applyStimulus('{1'b0, 2'd1, 8'h00, 4, 8'h99, 8'h99, 4, 1'b0});
    applyStimulus('{1'b1, 2'd3, 8'h42, 0, 8'h55, 8'h00, 4, 1'b1});
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
